// File: rtl/alu_muldiv_unit_if.sv
// Request/response bundle between the ALU input mux, the mul/div unit and
// the result consumer. The core drives requests and accepts results.
interface alu_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply (LSB first) and
// restoring division (MSB first), one bit per cycle, sign fix-up at the end.
module alu_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_muldiv_unit_if.slave   bus
);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    // Multiply: {partial product high, multiplier shifting out / product low}.
    // Divide: low half holds dividend shifting out and quotient shifting in.
    logic [2*XLEN-1:0] acc_q, acc_d;
    // Multiplicand for multiply, divisor for divide (both magnitudes).
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              ov_q, ov_d;

    logic              accept, is_div, signed_a, signed_b, sa, sb, b_zero, ovf;
    logic [XLEN-1:0]   abs_a, abs_b, div_sel;
    logic [XLEN:0]     mul_sum, rem_sh, trial;
    logic [2*XLEN-1:0] mul_full;

    // Next-state, operand preparation and per-cycle datapath step
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        res_d   = res_q;

        // kill wins over a request presented while idle
        accept   = bus.in_valid && (state_q == IDLE) && !bus.kill;
        is_div   = bus.op[2];
        signed_a = (bus.op == 3'b001) || (bus.op == 3'b010) || (bus.op[2] && !bus.op[0]);
        signed_b = (bus.op == 3'b001) || (bus.op[2] && !bus.op[0]);
        sa       = signed_a && bus.a[XLEN-1];
        sb       = signed_b && bus.b[XLEN-1];
        abs_a    = sa ? -bus.a : bus.a;
        abs_b    = sb ? -bus.b : bus.b;
        b_zero   = (bus.b == '0);
        ovf      = bus.op[2] && !bus.op[0] &&
                   (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == '1);

        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        rem_sh   = {rem_q, acc_q[XLEN-1]};
        // trial[XLEN] is the borrow: set when the shifted remainder < divisor
        trial    = rem_sh - {1'b0, opb_q};
        mul_full = neg_q ? -acc_q : acc_q;
        div_sel  = op_q[1] ? rem_q : acc_q[XLEN-1:0];

        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = bus.op;
                    neg_d = (bus.op[2] && bus.op[1]) ? sa : (sa ^ sb);
                    cnt_d = CNT_W'(XLEN - 1);
                    if (is_div && (b_zero || ovf)) begin
                        if (b_zero)
                            res_d = bus.op[1] ? bus.a : '1;
                        else
                            res_d = bus.op[1] ? '0 : bus.a;
                        state_d = DONE;
                    end else begin
                        opb_d   = is_div ? abs_b : abs_a;
                        acc_d   = {{XLEN{1'b0}}, (is_div ? abs_a : abs_b)};
                        rem_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[2]) begin
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~trial[XLEN]};
                        rem_d = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
                    end else begin
                        acc_d = {mul_sum, acc_q[XLEN-1:1]};
                    end
                    if (cnt_q == '0)
                        state_d = FIX;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                if (bus.kill) begin
                    state_d = IDLE;
                end else begin
                    if (op_q[2])
                        res_d = neg_q ? -div_sel : div_sel;
                    else if (op_q == 3'b000)
                        res_d = mul_full[XLEN-1:0];
                    else
                        res_d = mul_full[2*XLEN-1:XLEN];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.kill || (ov_q && bus.out_ready))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // out_valid trails entry into DONE by one cycle and drops on handoff
        ov_d = (state_q == DONE) && !bus.kill && !(ov_q && bus.out_ready);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            res_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
            ov_q    <= ov_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = ov_q;
    assign bus.result    = res_q;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Directed bench for alu_muldiv_unit: results, latency, backpressure, kill, reset.
module tb_alu_muldiv_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    bit   seen;

    always #5 clk = ~clk;

    alu_muldiv_unit_if #(.XLEN(32)) bus ();

    alu_muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure acceptance-to-out_valid latency, optionally stall
    // the result for 'hold' cycles, then hand it off.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int hold);
        int lat;
        bit rdy_hi;
        bit unstable;
        @(negedge clk);
        chk({tag, "_rdy_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a  = a;
        bus.b  = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        rdy_hi = 1'b0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy_hi = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, bus.result, exp_res);
        chk({tag, "_rdy_busy"}, 32'(rdy_hi), 32'd0);
        unstable = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            if (!bus.out_valid || bus.result !== exp_res || bus.in_ready) unstable = 1'b1;
        end
        if (hold > 0) chk({tag, "_hold"}, 32'(unstable), 32'd0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, "_ov_drop"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rdy_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = 3'b000;
        bus.a         = '0;
        bus.b         = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;

        #3;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Multiplies
        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0);

        // Divides
        run_op("div",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34, 0);
        run_op("rem",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34, 0);
        run_op("divu", 3'b101, 32'd100,      32'd7, 32'd14,       34, 10);
        run_op("remu", 3'b111, 32'd100,      32'd7, 32'd2,        34, 0);

        // Special cases, latency 1
        run_op("divu_z",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0);
        run_op("remu_z",  3'b111, 32'd5,        32'd0,        32'd5,        1, 0);
        run_op("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
        run_op("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

        // kill in CALC cycle 15
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 3'b000;
        bus.a  = 32'd5;
        bus.b  = 32'd6;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (14) @(negedge clk);
        bus.kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b0;
        chk("kill_calc_busy", 32'(bus.busy), 32'd0);
        chk("kill_calc_rdy", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("kill_calc_no_ov", 32'(seen), 32'd0);

        // kill beats in_valid while idle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.kill = 1'b1;
        bus.op = 3'b101;
        bus.a  = 32'd5;
        bus.b  = 32'd0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.kill = 1'b0;
        chk("kill_idle_busy", 32'(bus.busy), 32'd0);

        // kill drops a pending result in DONE
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("kill_done_ov", 32'(bus.out_valid), 32'd1);
        bus.kill = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.kill = 1'b0;
        chk("kill_done_drop", 32'(bus.out_valid), 32'd0);
        chk("kill_done_rdy", 32'(bus.in_ready), 32'd1);

        // asynchronous reset mid-CALC
        bus.in_valid = 1'b1;
        bus.op = 3'b011;
        bus.a  = 32'hFFFFFFFF;
        bus.b  = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_res", bus.result, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 34, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
